// File: rtl/ahb_bridge_pkg.sv
// ahb_bridge_pkg: shared AHB-Lite encodings, bridge FSM states and byte-strobe helper
package ahb_bridge_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE  = 3'd0;
   localparam logic [2:0] HSIZE_HALF  = 3'd1;
   localparam logic [2:0] HSIZE_WORD  = 3'd2;
   localparam logic [2:0] HSIZE_DWORD = 3'd3;

   typedef enum logic [1:0] {IDLE, REQ, ERR1, ERR2} bridge_state_t;

   // Lane mask for a beat of 2**size bytes starting at byte lane addr_lsb (up to 8 lanes)
   function automatic logic [7:0] wstrb_gen(input logic [2:0] size, input logic [2:0] addr_lsb);
      logic [7:0] mask;
      mask = (size == HSIZE_BYTE) ? 8'h01 :
             (size == HSIZE_HALF) ? 8'h03 :
             (size == HSIZE_WORD) ? 8'h0F : 8'hFF;
      return mask << addr_lsb;
   endfunction

endpackage

// File: rtl/ahb_bridge_timeout.sv
// ahb_bridge_timeout: saturating wait-state counter flagging the last permitted cycle
module ahb_bridge_timeout #(
   parameter int LIMIT = 8
) (
   input  logic hclk,
   input  logic hresetn,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int TO_W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;

   logic [TO_W-1:0] cnt;

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en && cnt != TO_W'(LIMIT))
         cnt <= cnt + 1'b1;
   end

   // Fires during the LIMIT-th unacknowledged cycle so the request never exceeds LIMIT cycles
   assign expired = en && (cnt >= TO_W'(LIMIT - 1));

endmodule

// File: rtl/ahb_lite_slave_bridge.sv
// ahb_lite_slave_bridge: AHB-Lite slave front end driving a single req/ack conduit target
module ahb_lite_slave_bridge
   import ahb_bridge_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 12,
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic                    hclk,
   input  logic                    hresetn,
   input  logic                    hsel,
   input  logic [ADDR_WIDTH-1:0]   haddr,
   input  logic [1:0]              htrans,
   input  logic                    hwrite,
   input  logic [2:0]              hsize,
   input  logic [2:0]              hburst,
   input  logic                    hready,
   input  logic [DATA_WIDTH-1:0]   hwdata,
   output logic [DATA_WIDTH-1:0]   hrdata,
   output logic                    hreadyout,
   output logic                    hresp,
   output logic                    con_req,
   output logic                    con_we,
   output logic [ADDR_WIDTH-1:0]   con_addr,
   output logic [DATA_WIDTH-1:0]   con_wdata,
   output logic [DATA_WIDTH/8-1:0] con_wstrb,
   input  logic                    con_ack,
   input  logic [DATA_WIDTH-1:0]   con_rdata,
   input  logic                    con_slverr
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int LSB_W  = $clog2(STRB_W);
   localparam logic [2:0] MAX_SIZE = 3'(LSB_W);

   bridge_state_t state, state_nx, next_beat;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [STRB_W-1:0] strb_q;
   logic we_q, accept, capture, legal, expired;
   logic [2:0] lsb_mask;
   logic unused_ok;

   assign unused_ok = ^{hburst, htrans[0]};

   assign accept   = hsel & hready & htrans[1];
   assign capture  = accept & hreadyout;
   assign lsb_mask = (hsize == HSIZE_BYTE) ? 3'd0 :
                     (hsize == HSIZE_HALF) ? 3'd1 :
                     (hsize == HSIZE_WORD) ? 3'd3 : 3'd7;
   assign legal    = (hsize <= MAX_SIZE) && ((haddr[2:0] & lsb_mask) == 3'd0);

   // A completing beat re-evaluates the bus, so the next address phase is taken in the same cycle
   always_comb begin
      next_beat = capture ? (legal ? REQ : ERR1) : IDLE;
      state_nx  = (state == ERR1) ? ERR2 :
                  (state == REQ)  ? (con_ack ? (con_slverr ? ERR1 : next_beat)
                                             : (expired ? ERR1 : REQ))
                                  : next_beat;
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state  <= IDLE;
         addr_q <= '0;
         we_q   <= 1'b0;
         strb_q <= '0;
      end else begin
         state <= state_nx;
         if (capture) begin
            addr_q <= haddr;
            we_q   <= hwrite;
            strb_q <= hwrite ? STRB_W'(wstrb_gen(hsize, 3'(haddr[LSB_W-1:0]))) : '1;
         end
      end
   end

   generate
      if (TIMEOUT_CYCLES > 0) begin : g_timeout
         ahb_bridge_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
            .hclk    (hclk),
            .hresetn (hresetn),
            .clr     (state != REQ),
            .en      ((state == REQ) & ~con_ack),
            .expired (expired)
         );
      end else begin : g_no_timeout
         assign expired = 1'b0;
      end
   endgenerate

   assign hreadyout = (state == REQ) ? (con_ack & ~con_slverr) : (state != ERR1);
   assign hresp     = (state == ERR1) | (state == ERR2);
   assign con_req   = (state == REQ);
   assign con_we    = we_q;
   assign con_addr  = addr_q;
   assign con_wstrb = strb_q;
   assign con_wdata = hwdata;
   assign hrdata    = ((state == REQ) & con_ack & ~we_q) ? con_rdata : '0;

endmodule
